// File: rtl/fc_act_serializer_pkg.sv
// Shared types and width helpers for the FC activation serializer.
package fc_pkg;

  function automatic int fc_acc_w(int n, int k);
    return 2 * n + k - 1;
  endfunction

  // A single-row vector still needs a one-bit index port.
  function automatic int fc_idx_w(int j);
    return (j > 1) ? $clog2(j) : 1;
  endfunction

  typedef enum logic {IDLE, EMIT} fc_ser_state_t;

endpackage

// File: rtl/fc_act_serializer_if.sv
// Input vector handshake plus output element stream of the activation serializer.
interface fc_act_serializer_if import fc_pkg::*; #(
  parameter int N = 8,
  parameter int J = 3,
  parameter int K = 3
);
  localparam int W     = fc_acc_w(N, K);
  localparam int IDX_W = fc_idx_w(J);

  logic                    in_valid;
  logic                    in_ready;
  logic [J*W-1:0]          in_data;
  logic [J*N-1:0]          in_bias;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [N-1:0]     out_data;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_last;

  modport slave (
    input  in_valid, in_data, in_bias, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

  modport master (
    output in_valid, in_data, in_bias, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/fc_act_serializer_act_unit.sv
// Combinational bias add, ReLU, arithmetic rescale and saturation of one accumulator row.
module fc_act_unit import fc_pkg::*; #(
  parameter  int N    = 8,
  parameter  int K    = 3,
  parameter  int FRAC = 4,
  localparam int W    = fc_acc_w(N, K)
) (
  input  logic signed [W-1:0] acc_i,
  input  logic signed [N-1:0] bias_i,
  output logic signed [N-1:0] y_o
);

  localparam logic [W:0] YMAX = (W+1)'((1 << (N-1)) - 1);

  // After ReLU the value is non-negative, so a logical shift equals truncation toward zero.
  function automatic logic [W:0] relu_shift(input logic signed [W:0] s);
    logic [W:0] r;
    r = s[W] ? '0 : $unsigned(s);
    return r >> FRAC;
  endfunction

  function automatic logic signed [N-1:0] saturate(input logic [W:0] q);
    logic signed [N-1:0] y;
    y = (q > YMAX) ? N'(YMAX) : N'(q);
    return y;
  endfunction

  logic signed [W:0] sum;

  // One guard bit makes the sum of a W-bit and an N-bit operand overflow-free.
  assign sum = {acc_i[W-1], acc_i} + {{(W+1-N){bias_i[N-1]}}, bias_i};
  assign y_o = saturate(relu_shift(sum));

endmodule

// File: rtl/fc_act_serializer.sv
// Captures an FC result vector and emits its activated elements one per cycle over valid/ready.
module fc_act_serializer import fc_pkg::*; #(
  parameter int N    = 8,
  parameter int J    = 3,
  parameter int K    = 3,
  parameter int FRAC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fc_act_serializer_if.slave   bus
);

  localparam int W     = fc_acc_w(N, K);
  localparam int IDX_W = fc_idx_w(J);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(J - 1);

  fc_ser_state_t       state_q, state_d;
  logic [IDX_W-1:0]    row_q, row_d, nxt_row;
  logic signed [W-1:0] acc_q  [J];
  logic signed [N-1:0] bias_q [J];
  logic signed [N-1:0] out_data_q;
  logic                out_last_q, out_last_d;
  logic                load_vec, upd_out, sel_in;
  logic                accept, fire;
  logic signed [W-1:0] act_acc;
  logic signed [N-1:0] act_bias, act_y;

  assign fire          = bus.out_valid & bus.out_ready;
  assign bus.out_valid = (state_q == EMIT);
  // Reopening on the final beat lets the next vector follow without a bubble.
  assign bus.in_ready  = ~rst & ((state_q == IDLE) | (fire & out_last_q));
  assign accept        = bus.in_valid & bus.in_ready;
  assign nxt_row       = row_q + IDX_W'(1);

  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = row_q;
  assign bus.out_last  = out_last_q;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    load_vec = 1'b0;
    upd_out  = 1'b0;
    sel_in   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = EMIT;
          row_d    = '0;
          load_vec = 1'b1;
          upd_out  = 1'b1;
          sel_in   = 1'b1;
        end
      end
      EMIT: begin
        if (fire) begin
          if (!out_last_q) begin
            row_d   = nxt_row;
            upd_out = 1'b1;
          end else if (accept) begin
            row_d    = '0;
            load_vec = 1'b1;
            upd_out  = 1'b1;
            sel_in   = 1'b1;
          end else begin
            state_d = IDLE;
            row_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_last_d = (row_d == LAST_ROW);

  // Row 0 of a freshly accepted vector comes straight from the input bus; later rows from the buffer.
  always_comb begin
    if (sel_in) begin
      act_acc  = bus.in_data[W-1:0];
      act_bias = bus.in_bias[N-1:0];
    end else begin
      act_acc  = acc_q[nxt_row];
      act_bias = bias_q[nxt_row];
    end
  end

  fc_act_unit #(
    .N    (N),
    .K    (K),
    .FRAC (FRAC)
  ) u_act (
    .acc_i  (act_acc),
    .bias_i (act_bias),
    .y_o    (act_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      for (int r = 0; r < J; r++) begin
        acc_q[r]  <= '0;
        bias_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      if (load_vec) begin
        for (int r = 0; r < J; r++) begin
          acc_q[r]  <= bus.in_data[(r+1)*W-1 -: W];
          bias_q[r] <= bus.in_bias[(r+1)*N-1 -: N];
        end
      end
      if (upd_out) begin
        out_data_q <= act_y;
        out_last_q <= out_last_d;
      end
    end
  end

endmodule
